// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared defaults and types for the two-port memory arbiter.
//   DEF_ADDR_W / DEF_DATA_W / DEF_DEPTH : default geometry (256 x 32 memory)
//   state_t                             : controller state (INIT sweep, RUN)
//   grant_t                             : one-hot grant, bit N = port N
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 256;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef logic [1:0] grant_t;

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: bundle of the two request/response ports and the memory bus.
//   req{0,1}_*  : request valid/ready handshake, we, addr, wdata, per-bit bwen
//   rsp{0,1}_*  : single-cycle read response pulse with data
//   mem_*       : single-port memory command bus (cen/wen active-low) and q
// Modports:
//   slave  : the arbiter side (consumes requests, drives memory commands)
//   master : the client + memory side (drives requests and mem_q)
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              req0_valid;
    logic              req0_ready;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic [DATA_W-1:0] req0_bwen;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic [DATA_W-1:0] req1_bwen;

    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    logic              mem_cen;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_bwen;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_d;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata, req0_bwen,
        input  req1_valid, req1_we, req1_addr, req1_wdata, req1_bwen,
        input  mem_q,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        output mem_cen, mem_wen, mem_bwen, mem_a, mem_d
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata, req0_bwen,
        output req1_valid, req1_we, req1_addr, req1_wdata, req1_bwen,
        output mem_q,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        input  mem_cen, mem_wen, mem_bwen, mem_a, mem_d
    );

endinterface

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: two-port round-robin grant, purely combinational.
//   valid      : in,  request present per port (already qualified by caller)
//   last_grant : in,  port that won the most recent accepted request
//   grant      : out, one-hot winner, zero when nothing is valid
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  grant_t valid,
    input  logic   last_grant,
    output grant_t grant
);

    always_comb begin
        grant = valid;
        // On a tie the port that did not win last time goes next.
        if (valid == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// mem_arb: two-port round-robin arbiter in front of a single-port memory.
// After reset it sweeps zeros through the whole memory (one word per cycle),
// then accepts at most one request per cycle, registers it onto mem_* for
// the following cycle and returns read data two cycles after acceptance.
//   clk, rst  : clock, synchronous active-high reset
//   init_done : high once the zero sweep has finished
//   bus       : request/response ports and memory bus (slave modport)
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
)(
    input  logic      clk,
    input  logic      rst,
    output logic      init_done,
    mem_arb_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              last_grant;

    grant_t            valid_run;
    grant_t            grant;
    logic              accept;
    logic              win;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] sel_bwen;

    logic              cen_p1;
    logic              wen_p1;
    logic [DATA_W-1:0] bwen_p1;
    logic [ADDR_W-1:0] a_p1;
    logic [DATA_W-1:0] d_p1;
    logic              vld_p1;
    logic              port_p1;
    logic              vld_p2;
    logic              port_p2;
    logic              rsp0_hit;
    logic              rsp1_hit;

    // Requests are invisible to the arbiter until the sweep is over.
    assign valid_run = {bus.req1_valid, bus.req0_valid} & {2{state == RUN}};

    mem_arb_rr u_rr (
        .valid      (valid_run),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign accept    = |grant;
    assign win       = grant[1];
    assign sel_we    = win ? bus.req1_we    : bus.req0_we;
    assign sel_addr  = win ? bus.req1_addr  : bus.req0_addr;
    assign sel_wdata = win ? bus.req1_wdata : bus.req0_wdata;
    assign sel_bwen  = win ? bus.req1_bwen  : bus.req0_bwen;

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];

    // ---- stage p1: command register, control FSM and read tracking ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= INIT;
            cnt        <= '0;
            init_done  <= 1'b0;
            last_grant <= 1'b1;
            cen_p1     <= 1'b1;
            wen_p1     <= 1'b1;
            bwen_p1    <= '0;
            a_p1       <= '0;
            d_p1       <= '0;
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
        end else begin
            // Idle command unless something below issues one.
            cen_p1  <= 1'b1;
            wen_p1  <= 1'b1;
            bwen_p1 <= '0;
            a_p1    <= '0;
            d_p1    <= '0;
            vld_p1  <= 1'b0;
            vld_p2  <= vld_p1;

            unique case (state)
                INIT: begin
                    cen_p1  <= 1'b0;
                    wen_p1  <= 1'b0;
                    bwen_p1 <= '1;
                    a_p1    <= cnt;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_ADDR) begin
                        cnt       <= '0;
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        cen_p1     <= 1'b0;
                        wen_p1     <= ~sel_we;
                        bwen_p1    <= sel_we ? sel_bwen  : '0;
                        a_p1       <= sel_addr;
                        d_p1       <= sel_we ? sel_wdata : '0;
                        vld_p1     <= ~sel_we;
                        last_grant <= win;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    // Port id rides alongside the read valid; it is only looked at when
    // the matching valid is set, so it carries no reset.
    always_ff @(posedge clk) begin
        port_p1 <= win;
        port_p2 <= port_p1;
    end

    assign bus.mem_cen  = cen_p1;
    assign bus.mem_wen  = wen_p1;
    assign bus.mem_bwen = bwen_p1;
    assign bus.mem_a    = a_p1;
    assign bus.mem_d    = d_p1;

    // ---- stage p2: memory q returns, steer to the requesting port ----
    assign rsp0_hit = vld_p2 & ~port_p2;
    assign rsp1_hit = vld_p2 &  port_p2;

    assign bus.rsp0_valid = rsp0_hit;
    assign bus.rsp1_valid = rsp1_hit;
    assign bus.rsp0_rdata = rsp0_hit ? bus.mem_q : '0;
    assign bus.rsp1_rdata = rsp1_hit ? bus.mem_q : '0;

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: bench for mem_arb paired with a 256x32 bit-write memory.
// A transaction-level model (shadow memory, response queue keyed by due
// cycle, round-robin winner from the request pair) is compared against the
// DUT on every cycle; directed scenarios add literal expectations.
module tb_mem_arb;

    logic clk = 1'b0;
    logic rst;
    logic init_done;

    mem_arb_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    mem_arb #(.ADDR_W(8), .DATA_W(32), .DEPTH(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .init_done (init_done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- 256x32 bit-write memory ----------------
    logic [31:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = $urandom();

    always @(posedge clk) begin
        if (bus.mem_cen == 1'b0) begin
            if (bus.mem_wen == 1'b0)
                mem[bus.mem_a] = (mem[bus.mem_a] & ~bus.mem_bwen) | (bus.mem_d & bus.mem_bwen);
            else
                bus.mem_q <= mem[bus.mem_a];
        end
    end

    // ---------------- behavioural model ----------------
    typedef struct {
        int          due;
        bit          port;
        logic [31:0] data;
    } rsp_t;

    rsp_t        rq[$];
    logic [31:0] shadow [256];
    bit          chk_on = 0;
    bit          m_run = 0;
    int          m_sweep = 0;
    bit          m_lastg = 1;
    bit          c_act = 0;
    bit          c_we = 0;
    logic [7:0]  c_a = '0;
    logic [31:0] c_d = '0;
    logic [31:0] c_bw = '0;
    int          w;
    bit          e0v, e1v;
    logic [31:0] ed;
    rsp_t        ent;

    always @(negedge clk) begin
        if (chk_on) begin
            w = -1;
            if (m_run) begin
                if (bus.req0_valid && bus.req1_valid) w = m_lastg ? 0 : 1;
                else if (bus.req0_valid)              w = 0;
                else if (bus.req1_valid)              w = 1;
            end
            chk("init_done", init_done, m_run);
            chk("req0_ready", bus.req0_ready, w == 0);
            chk("req1_ready", bus.req1_ready, w == 1);
            chk("mem_cen", bus.mem_cen, !c_act);
            chk("mem_wen", bus.mem_wen, !(c_act && c_we));
            chk("mem_bwen", bus.mem_bwen, (c_act && c_we) ? c_bw : 32'h0);
            chk("mem_a", bus.mem_a, c_act ? c_a : 8'h0);
            if (!c_act || c_we) chk("mem_d", bus.mem_d, c_act ? c_d : 32'h0);

            e0v = 0; e1v = 0; ed = '0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                ent = rq.pop_front();
                ed  = ent.data;
                if (ent.port) e1v = 1; else e0v = 1;
            end
            chk("rsp0_valid", bus.rsp0_valid, e0v);
            chk("rsp0_rdata", bus.rsp0_rdata, e0v ? ed : 32'h0);
            chk("rsp1_valid", bus.rsp1_valid, e1v);
            chk("rsp1_rdata", bus.rsp1_rdata, e1v ? ed : 32'h0);

            // Advance to what the next cycle must show.
            if (rst) begin
                m_run = 0; m_sweep = 0; m_lastg = 1; c_act = 0;
                rq.delete();
            end else if (!m_run) begin
                c_act = 1; c_we = 1; c_a = 8'(m_sweep); c_d = '0; c_bw = '1;
                m_sweep++;
                if (m_sweep == 256) begin
                    m_run = 1;
                    for (int i = 0; i < 256; i++) shadow[i] = '0;
                end
            end else if (w >= 0) begin
                c_act = 1;
                c_we  = (w == 1) ? bus.req1_we    : bus.req0_we;
                c_a   = (w == 1) ? bus.req1_addr  : bus.req0_addr;
                c_d   = (w == 1) ? bus.req1_wdata : bus.req0_wdata;
                c_bw  = (w == 1) ? bus.req1_bwen  : bus.req0_bwen;
                if (c_we) begin
                    shadow[c_a] = (shadow[c_a] & ~c_bw) | (c_d & c_bw);
                end else begin
                    ent.due = cyc + 2; ent.port = (w == 1); ent.data = shadow[c_a];
                    rq.push_back(ent);
                end
                m_lastg = (w == 1);
            end else begin
                c_act = 0;
            end
        end
    end

    // ---------------- response log for literal checks ----------------
    int          n0 = 0, n1 = 0;
    int          r0_cyc = -1, r1_cyc = -1;
    logic [31:0] r0_data = '0, r1_data = '0;

    always @(negedge clk) begin
        if (bus.rsp0_valid === 1'b1) begin n0++; r0_cyc = cyc; r0_data = bus.rsp0_rdata; end
        if (bus.rsp1_valid === 1'b1) begin n1++; r1_cyc = cyc; r1_data = bus.rsp1_rdata; end
    end

    // ---------------- stimulus ----------------
    task automatic idle_reqs();
        bus.req0_valid = 0; bus.req0_we = 0; bus.req0_addr = '0; bus.req0_wdata = '0; bus.req0_bwen = '0;
        bus.req1_valid = 0; bus.req1_we = 0; bus.req1_addr = '0; bus.req1_wdata = '0; bus.req1_bwen = '0;
    endtask

    // Issue one request on a single port; it is the only valid, so it is
    // accepted in the cycle it is presented. Returns at acceptance+1, +#1.
    task automatic do_req(input bit port, input bit we, input logic [7:0] addr,
                          input logic [31:0] wd, input logic [31:0] bw, output int acc);
        if (port) begin
            bus.req1_valid = 1; bus.req1_we = we; bus.req1_addr = addr; bus.req1_wdata = wd; bus.req1_bwen = bw;
        end else begin
            bus.req0_valid = 1; bus.req0_we = we; bus.req0_addr = addr; bus.req0_wdata = wd; bus.req0_bwen = bw;
        end
        @(negedge clk);
        acc = cyc;
        @(posedge clk); #1;
        idle_reqs();
    endtask

    task automatic rd_check(input bit port, input logic [7:0] addr, input logic [31:0] exp, input string nm);
        int acc;
        do_req(port, 1'b0, addr, '0, '0, acc);
        repeat (2) @(posedge clk);
        #1;
        chk({nm, "_lat"}, port ? r1_cyc : r0_cyc, acc + 2);
        chk(nm, port ? r1_data : r0_data, exp);
    endtask

    task automatic wait_init(input int c_start, input string nm);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (init_done === 1'b1) break;
        end
        chk(nm, cyc - c_start, 256);
    endtask

    int exp_seq [6];
    int g;
    int acc;
    int c0;
    int nb0, nb1;

    initial begin
        exp_seq = '{0, 1, 0, 1, 0, 1};
        rst = 1;
        idle_reqs();
        @(posedge clk);
        chk_on = 1;
        @(posedge clk); #1;
        rst = 0;
        c0 = cyc;
        wait_init(c0, "init_latency");
        @(posedge clk); #1;

        // Cleared memory reads back zero on both ports.
        rd_check(0, 8'hA5, 32'h0000_0000, "rd_cleared_p0");
        rd_check(1, 8'h3C, 32'h0000_0000, "rd_cleared_p1");

        // Full write then immediate read-back.
        do_req(0, 1'b1, 8'h10, 32'hDEAD_BEEF, 32'hFFFF_FFFF, acc);
        rd_check(0, 8'h10, 32'hDEAD_BEEF, "rd_after_wr");

        // Partial write into a cleared word.
        do_req(0, 1'b1, 8'h30, 32'hFFFF_FFFF, 32'h0000_FF00, acc);
        rd_check(0, 8'h30, 32'h0000_FF00, "rd_partial");

        // Port 1 writes, leaving port 1 as the last winner.
        do_req(1, 1'b1, 8'h20, 32'h1234_5678, 32'hFFFF_FFFF, acc);

        // Both ports read continuously for six cycles.
        nb0 = n0; nb1 = n1;
        bus.req0_valid = 1; bus.req0_we = 0; bus.req0_addr = 8'h10;
        bus.req1_valid = 1; bus.req1_we = 0; bus.req1_addr = 8'h20;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            g = bus.req1_ready ? 1 : (bus.req0_ready ? 0 : 9);
            chk($sformatf("rr_grant%0d", i), g, exp_seq[i]);
            @(posedge clk); #1;
        end
        idle_reqs();
        repeat (3) @(posedge clk);
        #1;
        chk("rr_rsp0_count", n0 - nb0, 3);
        chk("rr_rsp1_count", n1 - nb1, 3);
        chk("rr_rsp0_data", r0_data, 32'hDEAD_BEEF);
        chk("rr_rsp1_data", r1_data, 32'h1234_5678);

        // Reset one cycle after a read accept.
        do_req(0, 1'b0, 8'h10, '0, '0, acc);
        nb0 = n0;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        c0 = cyc;
        @(negedge clk);
        chk("rst_cmd_idle", bus.mem_cen, 1'b1);
        @(negedge clk);
        chk("sweep_restart_a", bus.mem_a, 8'h00);
        chk("sweep_restart_cen", bus.mem_cen, 1'b0);
        chk("sweep_restart_wen", bus.mem_wen, 1'b0);
        chk("sweep_restart_bwen", bus.mem_bwen, 32'hFFFF_FFFF);
        wait_init(c0, "reinit_latency");
        chk("no_rsp_after_rst", n0 - nb0, 0);
        @(posedge clk); #1;
        rd_check(0, 8'h10, 32'h0000_0000, "rd_after_reinit");

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_W, 8, memory address width
- DATA_W, 32, memory data width
- DEPTH, 256, words cleared by init sweep
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock, all logic on rising edge
- rst, in, 1, synchronous, active-high reset
- init_done, out, 1, high once the init sweep completes
- req0_valid / req1_valid, in, 1, request present
- req0_ready / req1_ready, out, 1, request accepted this cycle (combinational)
- req0_we / req1_we, in, 1, 1 = write, 0 = read
- req0_addr / req1_addr, in, ADDR_W, word address
- req0_wdata / req1_wdata, in, DATA_W, write data
- req0_bwen / req1_bwen, in, DATA_W, per-bit write enable (1 = write bit)
- rsp0_valid / rsp1_valid, out, 1, read data valid (single-cycle pulse)
- rsp0_rdata / rsp1_rdata, out, DATA_W, read data
- mem_cen, out, 1, memory chip enable, active-low
- mem_wen, out, 1, 0 = write, 1 = read
- mem_bwen, out, DATA_W, per-bit write enable
- mem_a, out, ADDR_W, address
- mem_d, out, DATA_W, write data
- mem_q, in, DATA_W, memory read data, valid one cycle after the read command

Function
REQ-003 The FSM SHALL have two states, INIT and RUN; reset enters INIT.
REQ-004 In INIT, the block SHALL write 0 to addresses 0..DEPTH-1, one word per cycle, with mem_bwen all ones, using an ADDR_W-bit counter; after address DEPTH-1 it SHALL move to RUN. The sweep takes exactly DEPTH cycles.
REQ-005 In INIT, req*_ready SHALL be 0 and init_done SHALL be 0. In RUN, init_done SHALL be 1.
REQ-006 In RUN, at most one request SHALL be accepted per cycle. reqN_ready SHALL be 1 only in the cycle in which reqN_valid is 1 and port N wins arbitration.
REQ-007 Arbitration SHALL be round-robin:
- With a single valid request, that request wins.
- With both valid, the port not granted last wins.
- last_grant resets to 1, so port 0 wins the first tie.
REQ-008 An accepted request SHALL be registered into the memory command registers at the accepting edge and driven on mem_* during the next cycle.
REQ-009 In any cycle with no registered command, mem_* SHALL be idle: cen=1, wen=1, bwen=0, a=0, d=0.
REQ-010 Command encoding:
- Read: cen=0, wen=1, bwen=0.
- Write: cen=0, wen=0, bwen=req_bwen, d=req_wdata.
REQ-011 A read accepted in cycle N SHALL produce rspN_valid=1 with rspN_rdata=mem_q in cycle N+2, for exactly one cycle, on the requesting port only. A 2-stage valid/port-id pipeline tracks the read.
REQ-012 Writes SHALL produce no response.
REQ-013 Requests SHALL reach memory in acceptance order, so a read accepted after a write to the same address returns the written data.
REQ-014 When no read response is due, rsp*_valid SHALL be 0 and rsp*_rdata SHALL be 0.
REQ-015 Back-to-back accepts SHALL be sustained at 1 per cycle, with no bubbles.

Reset
REQ-016 rst SHALL be sampled only on a rising clk edge.
REQ-017 While rst is high, the following SHALL hold: state=INIT, counter=0, last_grant=1, command registers idle, pipeline valids=0, init_done=0.
REQ-018 Reset asserted mid-sweep or with reads in flight SHALL discard the pending responses (no rsp pulses) and restart the full init sweep.

Structure
REQ-019 Package mem_arb_pkg SHALL hold the ADDR_W/DATA_W/DEPTH defaults and the state enum (INIT, RUN).
REQ-020 The two-port round-robin grant logic (valid pair plus last_grant register in, one-hot grant out) SHALL be the sub-module mem_arb_rr.

Verification
REQ-021 The bench SHALL pair mem_arb with the team's 256x32 bit-write memory model and cover these scenarios:
- Reset, then idle: init_done rises exactly 256 cycles after rst falls; reading any address returns 0x00000000.
- Port 0 writes 0xDEADBEEF to addr 0x10 with bwen all ones, then reads 0x10 the next cycle: rsp0_valid two cycles after the read accept, rdata = 0xDEADBEEF.
- Partial write of d=0xFFFFFFFF with bwen=0x0000FF00 to a cleared word: read returns 0x0000FF00.
- Both ports assert reads continuously for 6 cycles: grants alternate 0,1,0,1,0,1, and each rsp arrives on the correct port at N+2.
- Reset asserted one cycle after a read accept: no rsp pulse follows, and the init sweep restarts from address 0.
